// File: rtl/uart_receiver.sv
// UART receive stage: 16x oversampled 5-8 data bits, optional parity, 1/2 stop bits.
// Latency: 2-cycle synchronizer, then frame result loaded in the cycle of the last stop-bit sample.
// Backpressure: one-entry holding register; an unread frame is overwritten with an overrun pulse.
module uart_receiver #(
   parameter int CFG_REQ_CYCLES = 100000
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       enable_i,
   input  logic       ov_baud_rt_i,
   input  logic       rx_i,
   input  logic [1:0] data_width_i,
   input  logic [1:0] stop_bits_number_i,
   input  logic [1:0] parity_mode_i,
   input  logic       rx_read_i,
   output logic [7:0] rx_data_o,
   output logic       rx_valid_o,
   output logic       parity_err_o,
   output logic       frame_err_o,
   output logic       overrun_o,
   output logic       config_req_slv_o,
   output logic       rx_idle_o
);

   localparam int LW = $clog2(CFG_REQ_CYCLES + 1);

   localparam logic [2:0] RX_IDLE     = 3'd0;
   localparam logic [2:0] RX_START    = 3'd1;
   localparam logic [2:0] RX_DATA     = 3'd2;
   localparam logic [2:0] RX_PARITY   = 3'd3;
   localparam logic [2:0] RX_STOP     = 3'd4;
   localparam logic [2:0] RX_CFG_WAIT = 3'd5;

   logic          rx_meta, rx_s, rx_prev;
   logic [2:0]    state;
   logic [3:0]    cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          perr, ferr, stop2;
   logic [LW-1:0] low_cnt;

   logic       fall, two_stop, mid_bit, cfg_fire, stop_last, frame_done, ferr_next;
   logic [2:0] last_idx;

   // Frame-level decode of the live configuration and line events.
   always_comb begin
      fall       = rx_prev & ~rx_s;
      two_stop   = (stop_bits_number_i == 2'b01);
      last_idx   = 3'd4 + {1'b0, data_width_i};
      mid_bit    = ov_baud_rt_i && (cnt == 4'd15);
      cfg_fire   = ~rx_s && (low_cnt == LW'(CFG_REQ_CYCLES - 1));
      stop_last  = (state == RX_STOP) && mid_bit && (!two_stop || stop2);
      frame_done = stop_last && !cfg_fire;
      ferr_next  = ferr | ~rx_s;
      rx_idle_o  = (state == RX_IDLE);
   end

   // Two-flop synchronizer plus edge-detect history; idles high.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         rx_meta <= rx_i;
         rx_s    <= rx_meta;
         rx_prev <= rx_s;
      end
   end

   // Consecutive-low counter for the configuration request; saturates so it fires once per low period.
   always_ff @(posedge clk_i) begin
      if (rst_i)
         low_cnt <= '0;
      else if (rx_s)
         low_cnt <= '0;
      else if (low_cnt != LW'(CFG_REQ_CYCLES))
         low_cnt <= low_cnt + 1'b1;
   end

   // Receive FSM; a configuration request overrides and aborts any frame in flight.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state   <= RX_IDLE;
         cnt     <= '0;
         bit_idx <= '0;
         shreg   <= '0;
         perr    <= 1'b0;
         ferr    <= 1'b0;
         stop2   <= 1'b0;
      end else if (cfg_fire) begin
         state   <= RX_CFG_WAIT;
         cnt     <= '0;
         bit_idx <= '0;
      end else begin
         case (state)
            RX_IDLE: begin
               cnt     <= '0;
               bit_idx <= '0;
               if (fall && enable_i) begin
                  state <= RX_START;
                  shreg <= '0;
                  perr  <= 1'b0;
                  ferr  <= 1'b0;
                  stop2 <= 1'b0;
               end
            end
            RX_START: begin
               if (ov_baud_rt_i) begin
                  if (cnt == 4'd7) begin
                     cnt   <= '0;
                     state <= rx_s ? RX_IDLE : RX_DATA;
                  end else begin
                     cnt <= cnt + 1'b1;
                  end
               end
            end
            RX_DATA: begin
               if (mid_bit) begin
                  shreg[bit_idx] <= rx_s;
                  cnt            <= '0;
                  if (bit_idx == last_idx) begin
                     bit_idx <= '0;
                     state   <= parity_mode_i[1] ? RX_STOP : RX_PARITY;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else if (ov_baud_rt_i) begin
                  cnt <= cnt + 1'b1;
               end
            end
            RX_PARITY: begin
               if (mid_bit) begin
                  perr  <= (rx_s != (^shreg ^ parity_mode_i[0]));
                  cnt   <= '0;
                  state <= RX_STOP;
               end else if (ov_baud_rt_i) begin
                  cnt <= cnt + 1'b1;
               end
            end
            RX_STOP: begin
               if (mid_bit) begin
                  ferr <= ferr_next;
                  cnt  <= '0;
                  if (two_stop && !stop2)
                     stop2 <= 1'b1;
                  else
                     state <= RX_IDLE;
               end else if (ov_baud_rt_i) begin
                  cnt <= cnt + 1'b1;
               end
            end
            RX_CFG_WAIT: begin
               if (rx_s)
                  state <= RX_IDLE;
            end
            default: state <= RX_IDLE;
         endcase
      end
   end

   // Holding register with valid/read handshake; simultaneous load and read is not an overrun.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rx_data_o        <= '0;
         rx_valid_o       <= 1'b0;
         parity_err_o     <= 1'b0;
         frame_err_o      <= 1'b0;
         overrun_o        <= 1'b0;
         config_req_slv_o <= 1'b0;
      end else begin
         overrun_o        <= 1'b0;
         config_req_slv_o <= cfg_fire;
         if (frame_done) begin
            rx_data_o    <= shreg;
            parity_err_o <= perr;
            frame_err_o  <= ferr_next;
            rx_valid_o   <= 1'b1;
            overrun_o    <= rx_valid_o & ~rx_read_i;
         end else if (rx_read_i && rx_valid_o) begin
            rx_valid_o <= 1'b0;
         end
      end
   end

endmodule

// File: doc/uart_receiver.md
Name: uart_receiver

Overview:
- Serial receive stage of the UART controller; consumes the line driven by the transmitter of the far-end device.
- Oversamples the line with the shared 16x baud tick and assembles 5-8 bit frames, with optional parity and 1/2 stop bits.
- Presents each frame in a one-entry holding register with a valid/read handshake.
- Detects the long-low configuration request and signals it to the configuration logic as config_req_slv.

Parameters:
CFG_REQ_CYCLES, 100000, consecutive clk_i cycles of synchronized low line that constitute a configuration request; must not exceed the transmitter's low-hold count.

Ports:
clk_i  in  1  system clock
rst_i  in  1  synchronous active-high reset
enable_i  in  1  allows new frames to start
ov_baud_rt_i  in  1  16x baud tick, one clk_i cycle wide
rx_i  in  1  asynchronous serial line, idle high
data_width_i  in  2  00=5, 01=6, 10=7, 11=8 data bits
stop_bits_number_i  in  2  01=two stop bits; any other value=one
parity_mode_i  in  2  [1]=1 no parity; [0]: 0 even, 1 odd
rx_read_i  in  1  consumer pops the holding register
rx_data_o  out  8  received data, right-justified, upper unused bits 0
rx_valid_o  out  1  holding register full
parity_err_o  out  1  parity mismatch for the held frame
frame_err_o  out  1  stop bit sampled low for the held frame
overrun_o  out  1  one-cycle pulse: unread frame overwritten
config_req_slv_o  out  1  one-cycle pulse: configuration request detected
rx_idle_o  out  1  FSM in RX_IDLE

Behaviour:
- Synchronous active-high reset on clk_i only.
- Reset values: 2-flop synchronizer = 1; all registered outputs = 0; state RX_IDLE, so rx_idle_o = 1.
- Synchronizer: rx_i to rx_s, 2 cycles latency.
- rx_prev: register of rx_s; a falling edge is rx_prev=1 && rx_s=0.
- Bit counter cnt (4 bit) advances only on ov_baud_rt_i.
- RX_IDLE: cnt=0, bit index=0. Falling edge && enable_i -> RX_START. A level-low line without a falling edge does not start a frame.
- RX_START: on tick with cnt==7, sample rx_s.
  - rx_s=0 -> RX_DATA, cnt=0.
  - rx_s=1 (glitch) -> RX_IDLE, no outputs.
  - Any other tick: cnt+1.
- RX_DATA: on tick with cnt==15 (mid-bit), shift rx_s in LSB-first, bit index+1, cnt=0.
  - After the data_width_i-th bit: -> RX_PARITY if parity_mode_i[1]=0, else -> RX_STOP.
- RX_PARITY: on tick with cnt==15, sample the parity bit. Expected = XOR(data bits) for even, inverted for odd. Mismatch sets the internal perr. -> RX_STOP.
- RX_STOP: on tick with cnt==15, sample; rx_s=0 sets the internal ferr.
  - Two stop bits: the second is sampled 16 ticks later and both are checked.
  - After the last stop bit, in the same cycle: load rx_data_o, parity_err_o, frame_err_o; set rx_valid_o=1 -> RX_IDLE.
- Configuration inputs are sampled live; they must be stable during a frame.
- enable_i low mid-frame does not abort the frame.
- Holding register:
  - rx_read_i with rx_valid_o=1 clears rx_valid_o next cycle; the data and error outputs hold their last values.
  - Frame completes while rx_valid_o=1 and no rx_read_i that cycle: overwrite, rx_valid_o stays 1, overrun_o pulses.
  - Frame completes and rx_read_i in the same cycle: load new frame, rx_valid_o stays 1, no overrun.
  - rx_read_i with rx_valid_o=0 is ignored.
- Config request detection:
  - A low counter increments every clk_i cycle while rx_s=0 and clears when rx_s=1. It runs in all states and saturates.
  - When it reaches CFG_REQ_CYCLES: config_req_slv_o pulses for exactly one cycle, any frame in progress is aborted (no valid, no errors), and the FSM goes to RX_CFG_WAIT.
- RX_CFG_WAIT: stay until rx_s=1, then -> RX_IDLE. Only one pulse per low period.
- rx_idle_o is combinational: 1 only in RX_IDLE.
- Reset mid-frame: immediate return to RX_IDLE. Holding register cleared, no pulse on any output.

Test Plan:
- 8N1, byte 0xA5, tick every 4 clk: rx_valid_o rises once after stop-bit sample; rx_data_o=0xA5; parity_err_o=0, frame_err_o=0.
- 7E2, data 0x35, parity bit 1 (deliberately wrong, correct is 0): rx_data_o=0x35, parity_err_o=1; valid only after the second stop sample.
- 5O1, data 0x1F, stop bit driven 0: rx_data_o=0x1F, frame_err_o=1, parity_err_o=0. FSM returns to RX_IDLE, and a new frame starts only after the next falling edge.
- Low glitch of 5 ticks on idle line: FSM returns to RX_IDLE from RX_START; rx_valid_o stays 0.
- Two 8N1 frames 0x11 then 0x22 without rx_read_i: overrun_o pulses once, rx_data_o=0x22. Repeat with rx_read_i asserted on the completion cycle: no overrun.
- CFG_REQ_CYCLES=50, line low 80 cycles (also mid-frame): config_req_slv_o high exactly one cycle at the 50th low cycle; no rx_valid_o. The next frame after the line returns high decodes correctly.
